fc_layer_seq: RTL and testbench



---
 rtl/fc_seq_pkg.sv | 30 +++
 rtl/fc_seq_loader.sv | 65 ++++++
 rtl/fc_layer_seq.sv | 206 ++++++++++++++++++++
 tb/tb_fc_layer_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_seq_pkg.sv
// rtl/fc_seq_pkg.sv - shared state encoding and beat-count helpers for the FC layer sequencer
//
// Contents:
//   state_t           sequencer states IDLE/FETCH/CAPT/PUSH/ARM/RUN/DONE
//   WD_LIMIT_DEFAULT  default stall limit when FC_SEQ_WATCHDOG_EN is defined
//   nb_beats()        bias beats: one beat carries IN_CH words
//   nw_beats()        weight beats: one beat per (sequence position, output channel)
package fc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CAPT  = 3'd2,
    S_PUSH  = 3'd3,
    S_ARM   = 3'd4,
    S_RUN   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int WD_LIMIT_DEFAULT = 1024;

  function automatic int nb_beats(input int out_ch, input int in_ch);
    return (out_ch + in_ch - 1) / in_ch;
  endfunction

  function automatic int nw_beats(input int in_seq, input int out_ch);
    return in_seq * out_ch;
  endfunction

endpackage

// File: rtl/fc_seq_loader.sv
// rtl/fc_seq_loader.sv - parameter-load datapath: ROM fetch, capture hold register, beat counter
//
// Ports:
//   clk, RST        clock, synchronous active-high reset
//   state           current sequencer state (FETCH/CAPT/PUSH drive this block)
//   clr             clears the beat counter at the start of a new load
//   i_rom_data      ROM read data, valid the cycle after o_rom_en
//   i_layer_ack     layer ack of the beat currently presented in PUSH
//   o_rom_en        ROM read enable (FETCH only)
//   o_rom_addr      BASE + beat during FETCH, 0 otherwise
//   o_hold          captured beat presented to the layer
//   o_load_done     the last beat is being accepted this cycle
module fc_seq_loader
  import fc_seq_pkg::*;
#(
  parameter int DW     = 32,
  parameter int IN_CH  = 16,
  parameter int NBEATS = 6,
  parameter int AW     = 8,
  parameter int BASE   = 0
) (
  input  logic                clk,
  input  logic                RST,
  input  state_t              state,
  input  logic                clr,
  input  logic [DW*IN_CH-1:0] i_rom_data,
  input  logic                i_layer_ack,
  output logic                o_rom_en,
  output logic [AW-1:0]       o_rom_addr,
  output logic [DW*IN_CH-1:0] o_hold,
  output logic                o_load_done
);

  localparam int BW = $clog2(NBEATS + 1);
  localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);

  logic [BW-1:0] beat;
  logic          beat_acc;

  assign beat_acc = (state == S_PUSH) && i_layer_ack;

  always_ff @(posedge clk) begin
    if (RST) begin
      beat   <= '0;
      o_hold <= '0;
    end else begin
      if (clr) begin
        beat <= '0;
      end else if (beat_acc) begin
        beat <= beat + 1'b1;
      end
      // ROM data lands the cycle after FETCH, which is exactly CAPT.
      if (state == S_CAPT) begin
        o_hold <= i_rom_data;
      end
    end
  end

  always_comb begin
    o_rom_en    = (state == S_FETCH);
    o_rom_addr  = o_rom_en ? (AW'(BASE) + AW'(beat)) : '0;
    o_load_done = beat_acc && (beat == LAST);
  end

endmodule

// File: rtl/fc_layer_seq.sv
// rtl/fc_layer_seq.sv - sequencer for one FC layer: load bias/weights from ROM, then run vectors
//
// Optional feature macro: FC_SEQ_WATCHDOG_EN (adds o_err and parameter WD_LIMIT).
//
// Ports:
//   clk, RST            clock, synchronous active-high reset
//   i_start, i_num_vec  start pulse (IDLE only) and vector count sampled with it
//   o_busy, o_done      busy outside IDLE; one-cycle completion pulse
//   o_err               watchdog timeout flag, sticky until RST or next start (macro only)
//   o_rom_en/addr       parameter ROM read port, i_rom_data valid one cycle later
//   i_data/i_stb_in     upstream vector and strobe, o_ack_in back to upstream
//   o_layer_EN_w/EN_c   layer load / compute enables
//   o_layer_data/stb    data and strobe to the layer, i_layer_ack from it
//   i_layer_stb_out     layer output strobe, i_ack_out downstream ack (monitored)
module fc_layer_seq
  import fc_seq_pkg::*;
#(
  parameter int DW     = 32,
  parameter int IN_CH  = 16,
  parameter int IN_SEQ = 1,
  parameter int OUT_CH = 5,
  parameter int AW     = 8,
  parameter int BASE   = 0
`ifdef FC_SEQ_WATCHDOG_EN
  , parameter int WD_LIMIT = WD_LIMIT_DEFAULT
`endif
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                i_start,
  input  logic [15:0]         i_num_vec,
  output logic                o_busy,
  output logic                o_done,
`ifdef FC_SEQ_WATCHDOG_EN
  output logic                o_err,
`endif
  output logic                o_rom_en,
  output logic [AW-1:0]       o_rom_addr,
  input  logic [DW*IN_CH-1:0] i_rom_data,
  input  logic [DW*IN_CH-1:0] i_data,
  input  logic                i_stb_in,
  output logic                o_ack_in,
  output logic                o_layer_EN_w,
  output logic                o_layer_EN_c,
  output logic [DW*IN_CH-1:0] o_layer_data,
  output logic                o_layer_stb,
  input  logic                i_layer_ack,
  input  logic                i_layer_stb_out,
  input  logic                i_ack_out
);

  localparam int NB     = nb_beats(OUT_CH, IN_CH);
  localparam int NW     = nw_beats(IN_SEQ, OUT_CH);
  localparam int NBEATS = NB + NW;

  state_t              state, state_next;
  logic [15:0]         num_vec, vin, vout;
  logic                start_ok, vin_open, vout_open, in_acc, out_acc;
  logic                load_done, timeout;
  logic [DW*IN_CH-1:0] hold;

  assign start_ok  = (state == S_IDLE) && i_start;
  assign vin_open  = (vin != num_vec);
  assign vout_open = (vout != num_vec);
  // Input and output accepts are independent so a pipelined layer may
  // emit results while inputs are still flowing; both count in one cycle.
  assign in_acc  = (state == S_RUN) && vin_open && i_stb_in && i_layer_ack;
  assign out_acc = (state == S_RUN) && vout_open && i_layer_stb_out && i_ack_out;

  fc_seq_loader #(
    .DW     (DW),
    .IN_CH  (IN_CH),
    .NBEATS (NBEATS),
    .AW     (AW),
    .BASE   (BASE)
  ) u_loader (
    .clk         (clk),
    .RST         (RST),
    .state       (state),
    .clr         (start_ok),
    .i_rom_data  (i_rom_data),
    .i_layer_ack (i_layer_ack),
    .o_rom_en    (o_rom_en),
    .o_rom_addr  (o_rom_addr),
    .o_hold      (hold),
    .o_load_done (load_done)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      state   <= S_IDLE;
      num_vec <= '0;
      vin     <= '0;
      vout    <= '0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        num_vec <= i_num_vec;
        vin     <= '0;
        vout    <= '0;
      end else begin
        if (in_acc) begin
          vin <= vin + 16'd1;
        end
        if (out_acc) begin
          vout <= vout + 16'd1;
        end
      end
    end
  end

`ifdef FC_SEQ_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        stall;

  assign stall   = ((state == S_PUSH) && !i_layer_ack) ||
                   ((state == S_RUN) && !in_acc && !out_acc);
  // Fire on the stall cycle that would take the count to WD_LIMIT.
  assign timeout = stall && (wd_cnt == 16'(WD_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (RST) begin
      wd_cnt <= '0;
      o_err  <= 1'b0;
    end else begin
      if (start_ok) begin
        o_err <= 1'b0;
      end else if (timeout) begin
        o_err <= 1'b1;
      end
      if (stall && !timeout) begin
        wd_cnt <= wd_cnt + 16'd1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_layer_EN_w = 1'b0;
    o_layer_EN_c = 1'b0;
    o_layer_data = '0;
    o_layer_stb  = 1'b0;
    o_ack_in     = 1'b0;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          state_next = (i_num_vec == 16'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        o_layer_EN_w = 1'b1;
        o_layer_data = hold;
        state_next   = S_CAPT;
      end
      S_CAPT: begin
        o_layer_EN_w = 1'b1;
        o_layer_data = hold;
        state_next   = S_PUSH;
      end
      S_PUSH: begin
        o_layer_EN_w = 1'b1;
        o_layer_data = hold;
        o_layer_stb  = 1'b1;
        if (load_done) begin
          state_next = S_ARM;
        end else if (i_layer_ack) begin
          state_next = S_FETCH;
        end
      end
      S_ARM: begin
        o_layer_EN_c = 1'b1;
        state_next   = S_RUN;
      end
      S_RUN: begin
        o_layer_EN_c = 1'b1;
        o_layer_data = i_data;
        o_layer_stb  = i_stb_in && vin_open;
        o_ack_in     = i_layer_ack && vin_open;
        // Leave as soon as the final output accept happens, not a cycle later.
        if ((vout + {15'd0, out_acc}) == num_vec) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_done     = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        o_busy     = 1'b0;
        state_next = S_IDLE;
      end
    endcase
    if (timeout) begin
      state_next = S_IDLE;
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// tb/tb_fc_layer_seq.sv - randomized self-checking bench for fc_layer_seq against a transaction model
module tb_fc_layer_seq;

  localparam int DW     = 32;
  localparam int IN_CH  = 16;
  localparam int IN_SEQ = 1;
  localparam int OUT_CH = 5;
  localparam int AW     = 8;
  localparam int BASE   = 0;
  localparam int DWI    = DW * IN_CH;
  localparam int NBEATS = (OUT_CH + IN_CH - 1) / IN_CH + IN_SEQ * OUT_CH;

  logic           clk = 1'b0;
  logic           RST = 1'b1;
  logic           i_start = 1'b0;
  logic [15:0]    i_num_vec = '0;
  logic           o_busy, o_done, o_rom_en;
  logic [AW-1:0]  o_rom_addr;
  logic [DWI-1:0] i_rom_data;
  logic [DWI-1:0] i_data = '0;
  logic           i_stb_in = 1'b0;
  logic           o_ack_in, o_layer_EN_w, o_layer_EN_c, o_layer_stb;
  logic [DWI-1:0] o_layer_data;
  logic           i_layer_ack = 1'b0;
  logic           i_layer_stb_out = 1'b0;
  logic           i_ack_out = 1'b0;
`ifdef FC_SEQ_WATCHDOG_EN
  logic           o_err;
`endif

  int n_pass = 0;
  int n_total = 0;

  logic [DWI-1:0] rom [0:(1<<AW)-1];
  logic [DWI-1:0] rom_q;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_rom_en) rom_q <= rom[o_rom_addr];
  end
  assign i_rom_data = rom_q;

  fc_layer_seq #(
    .DW(DW), .IN_CH(IN_CH), .IN_SEQ(IN_SEQ), .OUT_CH(OUT_CH), .AW(AW), .BASE(BASE)
`ifdef FC_SEQ_WATCHDOG_EN
    , .WD_LIMIT(16)
`endif
  ) dut (
    .clk(clk), .RST(RST), .i_start(i_start), .i_num_vec(i_num_vec),
    .o_busy(o_busy), .o_done(o_done),
`ifdef FC_SEQ_WATCHDOG_EN
    .o_err(o_err),
`endif
    .o_rom_en(o_rom_en), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .i_data(i_data), .i_stb_in(i_stb_in), .o_ack_in(o_ack_in),
    .o_layer_EN_w(o_layer_EN_w), .o_layer_EN_c(o_layer_EN_c),
    .o_layer_data(o_layer_data), .o_layer_stb(o_layer_stb), .i_layer_ack(i_layer_ack),
    .i_layer_stb_out(i_layer_stb_out), .i_ack_out(i_ack_out)
  );

  function automatic logic [DWI-1:0] rand_vec();
    logic [DWI-1:0] v;
    for (int i = 0; i < IN_CH; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic test_reset;
    RST = 1'b1; i_start = 1'b1; i_num_vec = 16'd5; i_stb_in = 1'b1;
    i_layer_ack = 1'b1; i_layer_stb_out = 1'b1; i_ack_out = 1'b1; i_data = rand_vec();
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if ({o_busy, o_done, o_rom_en, o_ack_in, o_layer_EN_w, o_layer_EN_c, o_layer_stb} !== 7'd0)
      $display("FAIL reset_ctrl got=%b want=0000000",
               {o_busy, o_done, o_rom_en, o_ack_in, o_layer_EN_w, o_layer_EN_c, o_layer_stb});
    else n_pass++;
    n_total++;
    if (o_rom_addr !== '0) $display("FAIL reset_addr got=%0h want=0", o_rom_addr);
    else n_pass++;
    n_total++;
    if (o_layer_data !== '0) $display("FAIL reset_data got=%0h want=0", o_layer_data);
    else n_pass++;
    @(negedge clk);
    RST = 1'b0; i_start = 1'b0; i_stb_in = 1'b0; i_layer_ack = 1'b0;
    i_layer_stb_out = 1'b0; i_ack_out = 1'b0;
    @(negedge clk);
    #1;
    n_total++;
    if (o_busy !== 1'b0) $display("FAIL reset_idle_busy got=%b want=0", o_busy);
    else n_pass++;
  endtask

  // One full operation: start, model the ROM/layer/upstream/downstream, and
  // compare the observed transaction trace with what the layer contract implies.
  task automatic run_op(input int nv, input int ack_dly, input bit pipelined, input string name);
    logic [AW-1:0]  addrs[$];
    logic [DWI-1:0] beats[$];
    logic [DWI-1:0] prev_data;
    int exp_beats, exp_load, wait_cnt, enw_cycles, busy_cycles, in_acc, out_acc;
    int last_out_cyc, done_cyc, hold_off, gated_seen, arm_cyc;
    bit waiting, run_phase, first_run;
    bit stable_ok, enw_ok, arm_ok, gate_ok, fwd_ok, run_ok, ackgate_ok, addr_ok, data_ok;
    exp_beats = (nv > 0) ? NBEATS : 0;
    exp_load = exp_beats * (3 + ack_dly);
    wait_cnt = 0; enw_cycles = 0; busy_cycles = 0; in_acc = 0; out_acc = 0;
    last_out_cyc = -1; done_cyc = -1; hold_off = 0; gated_seen = 0; arm_cyc = -1;
    waiting = 0; run_phase = 0; first_run = 0; prev_data = '0;
    stable_ok = 1; enw_ok = 1; arm_ok = 1; gate_ok = 1; fwd_ok = 1; run_ok = 1;
    ackgate_ok = 1; addr_ok = 1; data_ok = 1;

    @(negedge clk);
    i_start = 1'b1; i_num_vec = 16'(nv); i_stb_in = 1'b0; i_layer_ack = 1'b0;
    i_layer_stb_out = 1'b0; i_ack_out = 1'b0;
    for (int cyc = 1; cyc <= 1500 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      i_start = 1'($urandom_range(0, 1));
      i_num_vec = 16'($urandom);
      i_data = rand_vec();
      if (first_run) begin
        i_stb_in = 1'b1; i_layer_ack = 1'b1; i_layer_stb_out = 1'b0; i_ack_out = 1'b1;
      end else if (run_phase) begin
        if (in_acc == nv) hold_off++;
        i_stb_in = pipelined ? ($urandom_range(0, 3) != 0) : 1'b1;
        i_layer_ack = ($urandom_range(0, 3) != 0);
        i_layer_stb_out = (out_acc < in_acc) &&
                          (pipelined ? ($urandom_range(0, 3) != 0) : (hold_off > 4));
        i_ack_out = ($urandom_range(0, 3) != 0);
      end else begin
        i_stb_in = 1'($urandom_range(0, 1)); i_layer_ack = 1'b0;
        i_layer_stb_out = 1'b0; i_ack_out = 1'($urandom_range(0, 1));
      end
      #1;
      if (!run_phase) i_layer_ack = o_layer_stb && (wait_cnt >= ack_dly);
      #1;
      if (o_busy) busy_cycles++;
      if (o_rom_en) addrs.push_back(o_rom_addr);
      if (o_layer_EN_w) enw_cycles++;
      if (o_done) done_cyc = cyc;
      if (!o_layer_EN_c && o_ack_in) ackgate_ok = 0;
      if (first_run) begin
        arm_cyc = cyc;
        if (!(o_layer_EN_c && !o_layer_EN_w && !o_ack_in && !o_layer_stb)) arm_ok = 0;
        first_run = 0;
      end else if (run_phase) begin
        if (!o_done && !o_layer_EN_c) run_ok = 0;
        if (in_acc == nv) begin
          if (i_stb_in) begin
            gated_seen++;
            if (o_ack_in || o_layer_stb) gate_ok = 0;
          end
        end else begin
          if (o_layer_stb !== i_stb_in || o_ack_in !== i_layer_ack) fwd_ok = 0;
          if (o_layer_stb && o_layer_data !== i_data) fwd_ok = 0;
          if (i_stb_in && i_layer_ack) in_acc++;
        end
        if (i_layer_stb_out && i_ack_out) begin
          out_acc++;
          last_out_cyc = cyc;
        end
      end else if (o_layer_stb) begin
        if (!o_layer_EN_w) enw_ok = 0;
        if (waiting && o_layer_data !== prev_data) stable_ok = 0;
        if (i_layer_ack) begin
          beats.push_back(o_layer_data);
          wait_cnt = 0; waiting = 0;
          if (beats.size() == exp_beats) begin
            run_phase = 1; first_run = 1;
          end
        end else begin
          wait_cnt++; waiting = 1; prev_data = o_layer_data;
        end
      end
    end

    n_total++;
    if (done_cyc < 0) $display("FAIL %s_timeout done_cyc=%0d want>=0", name, done_cyc);
    else n_pass++;
    n_total++;
    if (addrs.size() != exp_beats) $display("FAIL %s_rom_reads got=%0d want=%0d", name, addrs.size(), exp_beats);
    else n_pass++;
    for (int k = 0; k < addrs.size() && k < exp_beats; k++)
      if (addrs[k] !== AW'(BASE + k)) addr_ok = 0;
    n_total++;
    if (!addr_ok) $display("FAIL %s_rom_addr_order got=0 want=1", name);
    else n_pass++;
    n_total++;
    if (beats.size() != exp_beats) $display("FAIL %s_beats got=%0d want=%0d", name, beats.size(), exp_beats);
    else n_pass++;
    for (int k = 0; k < beats.size() && k < exp_beats; k++)
      if (beats[k] !== rom[BASE + k]) data_ok = 0;
    n_total++;
    if (!data_ok) $display("FAIL %s_beat_data got=0 want=1", name);
    else n_pass++;
    n_total++;
    if (enw_cycles != exp_load) $display("FAIL %s_enw_cycles got=%0d want=%0d", name, enw_cycles, exp_load);
    else n_pass++;
    n_total++;
    if (busy_cycles != done_cyc) $display("FAIL %s_busy_cycles got=%0d want=%0d", name, busy_cycles, done_cyc);
    else n_pass++;
    n_total++;
    if (!(stable_ok && enw_ok && ackgate_ok))
      $display("FAIL %s_load_stable got=%b%b%b want=111", name, stable_ok, enw_ok, ackgate_ok);
    else n_pass++;
    if (nv == 0) begin
      n_total++;
      if (done_cyc != 1) $display("FAIL %s_zero_done got=%0d want=1", name, done_cyc);
      else n_pass++;
    end else begin
      n_total++;
      if (arm_cyc != exp_load + 1 || !arm_ok)
        $display("FAIL %s_arm got=%0d/%b want=%0d/1", name, arm_cyc, arm_ok, exp_load + 1);
      else n_pass++;
      n_total++;
      if (in_acc != nv || out_acc != nv)
        $display("FAIL %s_vec_counts got=%0d/%0d want=%0d/%0d", name, in_acc, out_acc, nv, nv);
      else n_pass++;
      n_total++;
      if (done_cyc != last_out_cyc + 1)
        $display("FAIL %s_done_time got=%0d want=%0d", name, done_cyc, last_out_cyc + 1);
      else n_pass++;
      n_total++;
      if (!(gate_ok && fwd_ok && run_ok))
        $display("FAIL %s_run_fwd got=%b%b%b want=111", name, gate_ok, fwd_ok, run_ok);
      else n_pass++;
      if (!pipelined) begin
        n_total++;
        if (gated_seen < 4) $display("FAIL %s_gated_strobes got=%0d want>=4", name, gated_seen);
        else n_pass++;
      end
    end
    @(negedge clk);
    i_start = 1'b0; i_stb_in = 1'b0; i_layer_ack = 1'b0; i_layer_stb_out = 1'b0; i_ack_out = 1'b0;
    #1;
    n_total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0)
      $display("FAIL %s_after_done got=%b%b want=00", name, o_busy, o_done);
    else n_pass++;
  endtask

  task automatic test_basic;      run_op(3, 0, 1'b1, "basic");  endtask
  task automatic test_ack_delay;  run_op(4, 4, 1'b1, "ackdly"); endtask
  task automatic test_zero_vec;   run_op(0, 0, 1'b1, "zero");   endtask
  task automatic test_input_gate; run_op(3, 0, 1'b0, "gate");   endtask

  task automatic test_back_to_back;
    run_op(2, $urandom_range(0, 2), 1'b1, "b2b_a");
    run_op(5, $urandom_range(0, 2), 1'b1, "b2b_b");
  endtask

  task automatic test_abort;
    int beats;
    bit found;
    beats = 0; found = 0;
    @(negedge clk);
    i_start = 1'b1; i_num_vec = 16'd2; i_layer_ack = 1'b0; i_stb_in = 1'b0;
    for (int cyc = 1; cyc <= 200 && !found; cyc++) begin
      @(negedge clk);
      i_start = 1'b0; i_layer_ack = 1'b0; i_stb_in = 1'b1;
      #1;
      if (o_layer_stb && beats < 2) i_layer_ack = 1'b1;
      #1;
      if (o_layer_stb && o_layer_EN_w) begin
        if (beats == 2) found = 1;
        else beats++;
      end
    end
    n_total++;
    if (!found) $display("FAIL abort_third_push got=0 want=1");
    else n_pass++;
    RST = 1'b1; i_layer_ack = 1'b1; i_stb_in = 1'b1; i_layer_stb_out = 1'b1; i_ack_out = 1'b1;
    @(negedge clk);
    #1;
    n_total++;
    if ({o_busy, o_done, o_rom_en, o_ack_in, o_layer_EN_w, o_layer_EN_c, o_layer_stb} !== 7'd0)
      $display("FAIL abort_ctrl got=%b want=0000000",
               {o_busy, o_done, o_rom_en, o_ack_in, o_layer_EN_w, o_layer_EN_c, o_layer_stb});
    else n_pass++;
    n_total++;
    if (o_layer_data !== '0 || o_rom_addr !== '0)
      $display("FAIL abort_data got=%0h/%0h want=0/0", o_layer_data, o_rom_addr);
    else n_pass++;
    RST = 1'b0; i_layer_ack = 1'b0; i_stb_in = 1'b0; i_layer_stb_out = 1'b0; i_ack_out = 1'b0;
    run_op(1, 1, 1'b1, "restart");
  endtask

`ifdef FC_SEQ_WATCHDOG_EN
  task automatic test_watchdog;
    int first_push, err_cyc;
    bit busy_at_err, saw_done;
    first_push = -1; err_cyc = -1; busy_at_err = 1; saw_done = 0;
    @(negedge clk);
    i_start = 1'b1; i_num_vec = 16'd1; i_layer_ack = 1'b0;
    for (int cyc = 1; cyc <= 100 && err_cyc < 0; cyc++) begin
      @(negedge clk);
      i_start = 1'b0; i_layer_ack = 1'b0;
      #2;
      if (o_layer_stb && first_push < 0) first_push = cyc;
      if (o_done) saw_done = 1;
      if (o_err && err_cyc < 0) begin
        err_cyc = cyc;
        busy_at_err = o_busy;
      end
    end
    n_total++;
    if (first_push != 3 || err_cyc != first_push + 16)
      $display("FAIL wd_err_time got=%0d/%0d want=3/19", first_push, err_cyc);
    else n_pass++;
    n_total++;
    if (busy_at_err !== 1'b0 || saw_done) $display("FAIL wd_idle got=%b%b want=00", busy_at_err, saw_done);
    else n_pass++;
    @(negedge clk);
    i_start = 1'b1; i_num_vec = 16'd0;
    @(negedge clk);
    i_start = 1'b0;
    #1;
    n_total++;
    if (o_err !== 1'b0 || o_done !== 1'b1) $display("FAIL wd_clear got=%b%b want=01", o_err, o_done);
    else n_pass++;
    @(negedge clk);
  endtask
`endif

  initial begin
    for (int a = 0; a < (1 << AW); a++) rom[a] = rand_vec();
    test_reset;
    test_basic;
    test_ack_delay;
    test_zero_vec;
    test_input_gate;
    test_abort;
    test_back_to_back;
`ifdef FC_SEQ_WATCHDOG_EN
    test_watchdog;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
